// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the I-cache
// (read-only) and the D-cache (read/write). Round-robin under contention,
// one transaction in flight, request captured into registers on grant.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_e;

    state_e                state_q, state_d;
    logic                  last_d_q, last_d_d;     // 1: D-cache was granted last
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    // Under contention D wins only when I was the last one served.
    assign grant_d = d_req & ~(i_req & last_d_q);

    // State and captured request/response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b1;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
        end
    end

    // Next state: grant in IDLE, wait for memory in BUSY, one pulse in DONE
    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (grant_d) begin
                        // read+write together is illegal; the write wins
                        pmem_address_d = d_address;
                        pmem_wdata_d   = d_wdata;
                        pmem_write_d   = d_write;
                        pmem_read_d    = ~d_write;
                        last_d_d       = 1'b1;
                        state_d        = BUSY_D;
                    end else begin
                        pmem_address_d = i_address;
                        pmem_read_d    = 1'b1;
                        pmem_write_d   = 1'b0;
                        last_d_d       = 1'b0;
                        state_d        = BUSY_I;
                    end
                end
            end
            BUSY_I: begin
                if (pmem_resp) begin
                    i_rdata_d    = pmem_rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE_I;
                end
            end
            BUSY_D: begin
                if (pmem_resp) begin
                    if (pmem_read_q) d_rdata_d = pmem_rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE_D;
                end
            end
            DONE_I, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Outputs: completion pulses decoded from state, the rest straight from registers
    always_comb begin
        i_resp       = (state_q == DONE_I);
        d_resp       = (state_q == DONE_D);
        i_rdata      = i_rdata_q;
        d_rdata      = d_rdata_q;
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        pmem_address = pmem_address_q;
        pmem_wdata   = pmem_wdata_q;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model (who gets served, what memory should see,
// what line each cache should end up holding).
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [15:0]  i_address, d_address;
    logic [127:0] d_wdata, pmem_rdata;
    logic [127:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [15:0]  pmem_address;

    int checks = 0;
    int errors = 0;

    // model state
    bit           m_last;     // 1: D served last
    logic [127:0] m_wdata, m_irdata, m_drdata;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round-robin rule: a lone requester wins; with both, the one not served last.
    function automatic bit pick(bit ir, bit dr, bit last);
        if (ir && dr) return ~last;
        return dr;
    endfunction

    task automatic model_reset();
        m_last   = 1'b1;
        m_wdata  = '0;
        m_irdata = '0;
        m_drdata = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_i_resp"}, 128'(i_resp), 128'(0));
        chk({tag, "_d_resp"}, 128'(d_resp), 128'(0));
        chk({tag, "_pread"}, 128'(pmem_read), 128'(0));
        chk({tag, "_pwrite"}, 128'(pmem_write), 128'(0));
        chk({tag, "_i_rdata"}, i_rdata, m_irdata);
        chk({tag, "_d_rdata"}, d_rdata, m_drdata);
    endtask

    // Serve one transaction as the memory. Called at a negedge in IDLE with
    // requests already driven; returns at the negedge of the following IDLE.
    task automatic serve(input int lat, input bit linger, output bit who);
        bit           ew;
        logic [15:0]  ea;
        logic [127:0] rd;
        int           waited;
        who    = pick(i_read, d_read | d_write, m_last);
        m_last = who;
        ew     = who & d_write;
        ea     = who ? d_address : i_address;
        if (who) m_wdata = d_wdata;
        rd     = rnd128();
        waited = 0;
        while (!(pmem_read || pmem_write) && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        chk("grant_latency", 128'(waited), 128'(1));
        chk("grant_write", 128'(pmem_write), 128'(ew));
        chk("grant_read", 128'(pmem_read), 128'(!ew));
        chk("grant_addr", 128'(pmem_address), 128'(ea));
        chk("grant_wdata", pmem_wdata, m_wdata);
        for (int c = 0; c < lat; c++) begin
            // requester inputs are ignored while busy
            if (who) begin d_address = 16'($urandom); d_wdata = rnd128(); end
            else     i_address = 16'($urandom);
            @(negedge clk);
            chk("busy_write", 128'(pmem_write), 128'(ew));
            chk("busy_read", 128'(pmem_read), 128'(!ew));
            chk("busy_addr", 128'(pmem_address), 128'(ea));
            chk("busy_wdata", pmem_wdata, m_wdata);
            chk("busy_resp", 128'({i_resp, d_resp}), 128'(0));
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        @(negedge clk);
        if (!ew) begin
            if (who) m_drdata = rd;
            else     m_irdata = rd;
        end
        chk("done_i_resp", 128'(i_resp), 128'(!who));
        chk("done_d_resp", 128'(d_resp), 128'(who));
        chk("done_strobes", 128'({pmem_read, pmem_write}), 128'(0));
        chk("done_i_rdata", i_rdata, m_irdata);
        chk("done_d_rdata", d_rdata, m_drdata);
        if (who) begin d_read = 1'b0; d_write = 1'b0; end
        else     i_read = 1'b0;
        if (!linger) pmem_resp = 1'b0;
        pmem_rdata = rnd128();
        @(negedge clk);
        pmem_resp = 1'b0;
        chk_idle_outputs("after");
    endtask

    initial begin
        bit who;
        bit i_pend, d_pend;
        rst_n = 1'b0;
        {i_read, d_read, d_write, pmem_resp} = '0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_addr", 128'(pmem_address), 128'(0));
        chk("reset_wdata", pmem_wdata, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: I-only read with fixed pattern
        i_read = 1'b1; i_address = 16'h0040;
        begin : t1
            int waited;
            waited = 0;
            while (!pmem_read && waited < 5) begin @(negedge clk); waited++; end
            chk("t1_latency", 128'(waited), 128'(1));
            chk("t1_addr", 128'(pmem_address), 128'(16'h0040));
            repeat (3) @(negedge clk);
            pmem_resp = 1'b1; pmem_rdata = {16{8'hA5}};
            @(negedge clk);
            chk("t1_i_resp", 128'(i_resp), 128'(1));
            chk("t1_d_resp", 128'(d_resp), 128'(0));
            chk("t1_i_rdata", i_rdata, {16{8'hA5}});
            i_read = 1'b0; pmem_resp = 1'b0;
            @(negedge clk);
            chk("t1_pulse_once", 128'(i_resp), 128'(0));
            m_last = 1'b0; m_irdata = {16{8'hA5}};
        end

        // 2: D write-back
        d_write = 1'b1; d_address = 16'h1230; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        serve(3, 1'b0, who);
        chk("t2_who", 128'(who), 128'(1));

        // 3: simultaneous requests out of reset: I first
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h0100;
        d_read = 1'b1; d_address = 16'h0200;
        serve(1, 1'b0, who);
        chk("t3_first", 128'(who), 128'(0));
        serve(2, 1'b0, who);
        chk("t3_second", 128'(who), 128'(1));

        // 4: sustained contention, 6 grants alternate I, D, ...
        for (int k = 0; k < 6; k++) begin
            if (!i_read) begin i_read = 1'b1; i_address = 16'($urandom); end
            if (!(d_read || d_write)) begin
                d_address = 16'($urandom); d_wdata = rnd128();
                if ($urandom_range(1)) d_write = 1'b1; else d_read = 1'b1;
            end
            serve($urandom_range(0, 3), 1'b0, who);
            chk("t4_seq", 128'(who), 128'(k % 2));
        end
        serve(1, 1'b0, who);   // drain the leftover request

        // 5: reset while D write is busy
        d_write = 1'b1; d_address = 16'h5550; d_wdata = rnd128();
        @(negedge clk);
        chk("t5_busy", 128'(pmem_write), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_drop", 128'(pmem_write), 128'(0));
        chk("t5_addr_clr", 128'(pmem_address), 128'(0));
        model_reset();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t5_in_reset");
        rst_n = 1'b1; d_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t5_release");
        d_write = 1'b1; d_address = 16'h0770; d_wdata = rnd128();
        serve(2, 1'b0, who);
        chk("t5_who", 128'(who), 128'(1));

        // 6: illegal read+write (write wins), then stray pmem_resp in IDLE
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0880; d_wdata = rnd128();
        serve(1, 1'b1, who);
        pmem_resp = 1'b1;
        repeat (2) begin
            pmem_rdata = rnd128();
            @(negedge clk);
            chk_idle_outputs("t6_stray");
        end
        pmem_resp = 1'b0;
        i_read = 1'b1; i_address = 16'h0990;
        serve(0, 1'b0, who);
        chk("t6_after_stray", 128'(who), 128'(0));

        // randomized traffic against the model
        i_pend = 1'b0; d_pend = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!i_read && $urandom_range(2) != 0) begin
                i_read = 1'b1; i_address = 16'($urandom);
            end
            if (!(d_read || d_write) && $urandom_range(2) != 0) begin
                d_address = 16'($urandom); d_wdata = rnd128();
                case ($urandom_range(3))
                    0, 1: d_read = 1'b1;
                    2:    d_write = 1'b1;
                    default: begin d_read = 1'b1; d_write = 1'b1; end
                endcase
            end
            if (!i_read && !(d_read || d_write)) begin
                i_read = 1'b1; i_address = 16'($urandom);
            end
            serve($urandom_range(0, 4), bit'($urandom_range(1)), who);
        end
        while (i_read || d_read || d_write) serve(1, 1'b0, who);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 128-bit physical-memory port between a read-only instruction cache and a read/write data cache (split-cache system).
- Sits between both caches' pmem-side interfaces and the physical memory.
- Arbitrates round-robin under contention. One line transaction is in flight at a time.
- Registers each granted request so memory sees stable address and data for the whole transaction.

Parameters:
ADDR_WIDTH, 16, byte address width of line requests
LINE_WIDTH, 128, cache line / memory data width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line read request, held until i_resp
i_address  in  ADDR_WIDTH  I-cache line address
i_rdata  out  LINE_WIDTH  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write-back request, held until d_resp
d_address  in  ADDR_WIDTH  D-cache line address
d_wdata  in  LINE_WIDTH  D-cache write-back line
d_rdata  out  LINE_WIDTH  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read strobe, held until pmem_resp
pmem_write  out  1  memory write strobe, held until pmem_resp
pmem_address  out  ADDR_WIDTH  registered memory address
pmem_wdata  out  LINE_WIDTH  registered write data
pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion, one or more cycles high

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; last_grant=D.
  - pmem_read, pmem_write, i_resp and d_resp all 0.
  - pmem_address, pmem_wdata, i_rdata and d_rdata all 0.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: sample the requests; i_req=i_read; d_req=d_read|d_write.
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant the requester not equal to last_grant.
  - On grant at the clock edge:
    - Capture address (and d_wdata for D) into the pmem_* registers.
    - Set pmem_read or pmem_write.
    - Update last_grant.
    - Enter BUSY_I or BUSY_D.
  - d_read and d_write both high is illegal; write wins and pmem_write alone is driven.
- BUSY_x:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are held constant.
  - Requester inputs are ignored.
  - On a cycle with pmem_resp=1: at the edge, capture pmem_rdata into x_rdata (reads only; x_rdata is unchanged on writes), clear pmem strobes, enter DONE_x.
- DONE_x:
  - x_resp=1 for exactly one cycle; x_rdata is valid in that cycle and held afterwards until the next read completion for x.
  - Next state is always IDLE.
  - pmem strobes are 0, so a lingering pmem_resp is ignored.
- Latency:
  - Uncontended grant occurs 1 cycle after the request is seen.
  - x_resp asserts 1 cycle after the pmem_resp cycle.
  - Minimum turnaround between back-to-back transactions is 1 IDLE cycle.
- Fairness: under continuous contention, grants alternate I, D, I, D...; neither side waits more than one transaction.
- Requester drops its request mid-transaction: the transaction still completes to memory and resp is still pulsed (caches never do this; no abort support).
- pmem_resp while in IDLE: ignored.
- Reset asserted mid-transaction: everything returns to reset values immediately. No resp is pulsed, and the memory strobe drops asynchronously.

Test Plan:
1. I-only read:
   - Stimulus: i_read=1, i_address=16'h0040; memory replies after 3 cycles with rdata=128'hA5..A5.
   - Required: pmem_read=1 with pmem_address=16'h0040 one cycle after the request. i_resp pulses once with i_rdata=128'hA5..A5. d_resp stays 0.
2. D write-back:
   - Stimulus: d_write=1, d_address=16'h1230, d_wdata=128'h0123..CDEF.
   - Required: pmem_write=1 with matching address and data, held stable until pmem_resp. d_resp pulses once; d_rdata is unchanged.
3. Simultaneous requests out of reset:
   - Stimulus: i_read and d_read raised in the same cycle.
   - Required: I is served first (last_grant resets to D), then D after one IDLE cycle. Resp order is i_resp then d_resp.
4. Sustained contention:
   - Stimulus: both requesters re-request immediately after each resp, for 6 transactions.
   - Required: grant sequence I, D, I, D, I, D.
5. Reset mid-operation:
   - Stimulus: rst_n pulled low while BUSY_D with pmem_write=1.
   - Required: pmem_write=0 immediately and no d_resp. After release, the next d_write is served normally.
6. Illegal and stray inputs:
   - Stimulus: d_read=d_write=1; separately, pmem_resp=1 while IDLE.
   - Required: only pmem_write is driven in the first case. The stray pmem_resp produces no resp and no state change.
